// File: rtl/rgmii_tx_gen_if.sv
// rgmii_tx_gen_if
// GMII-style byte stream from the MAC toward the RGMII transmit nibble generator.
//   gmii_txd    : transmit byte (MAC -> generator)
//   gmii_tx_en  : transmit enable (MAC -> generator)
//   gmii_tx_er  : transmit error (MAC -> generator)
//   gmii_clk_en : byte-slot strobe (generator -> MAC). The MAC inputs are sampled
//                 at the rising clk edge that ends a cycle with this strobe high.
// Modports: master = MAC side, slave = generator side.
interface rgmii_tx_gen_if;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       gmii_clk_en;

  modport master (output gmii_txd, output gmii_tx_en, output gmii_tx_er, input gmii_clk_en);
  modport slave  (input gmii_txd, input gmii_tx_en, input gmii_tx_er, output gmii_clk_en);
endinterface

// File: rtl/rgmii_tx_gen.sv
// rgmii_tx_gen
// Transmit-side RGMII nibble generator. Turns the GMII byte stream into per-half-cycle
// values for a downstream DDR output stage (TXD[3:0]+TX_CTL and the forwarded TXC).
// A single 125 MHz clock serves all speeds; 10/100 timing comes from a byte-slot
// counter and the gmii_clk_en strobe back to the MAC.
// Ports:
//   clk, rst_n           : logic clock, asynchronous active-low reset
//   gmii (slave)         : gmii_txd/gmii_tx_en/gmii_tx_er in, gmii_clk_en out
//   speed[1:0]           : 10 = 1000M, 01 = 100M, 00 = 10M, 11 = 1000M
//   txd_d1/txd_d2        : TXD for rising / falling half of clk
//   txctl_d1/txctl_d2    : TX_CTL for rising / falling half
//   txc_d1/txc_d2        : forwarded TXC for rising / falling half
module rgmii_tx_gen (
  input  logic                 clk,
  input  logic                 rst_n,
  rgmii_tx_gen_if.slave        gmii,
  input  logic [1:0]           speed,
  output logic [3:0]           txd_d1,
  output logic [3:0]           txd_d2,
  output logic                 txctl_d1,
  output logic                 txctl_d2,
  output logic                 txc_d1,
  output logic                 txc_d2
);

  typedef enum logic [1:0] {
    SPD_10   = 2'b00,
    SPD_100  = 2'b01,
    SPD_1000 = 2'b10
  } speed_t;

  speed_t     lat_speed;
  logic [7:0] lat_byte;
  logic       lat_en;
  logic       lat_er;
  logic [6:0] cnt;
  logic [6:0] last_cnt;
  logic       capture;

  logic [3:0] nx_txd_d1;
  logic [3:0] nx_txd_d2;
  logic       nx_txc_d1;
  logic       nx_txc_d2;
  logic       hi_half;
  logic [6:0] h;

  // 2'b11 is folded into 1000M so the latched speed is always a legal enum value.
  function automatic speed_t decode_speed(input logic [1:0] s);
    case (s)
      2'b01:   decode_speed = SPD_100;
      2'b00:   decode_speed = SPD_10;
      default: decode_speed = SPD_1000;
    endcase
  endfunction

  // Last phase of the byte in flight. It depends only on the latched speed, so a
  // speed change on the input cannot shorten or stretch the current byte.
  always_comb begin
    case (lat_speed)
      SPD_100: last_cnt = 7'd9;
      SPD_10:  last_cnt = 7'd99;
      default: last_cnt = 7'd0;
    endcase
  end

  assign capture          = (cnt == last_cnt);
  assign gmii.gmii_clk_en = capture;

  // Per-phase output values. TXC is described in half-cycles: within a nibble of
  // N half-cycles the first N/2 are high, so TXC rises exactly at each nibble change.
  // 100M: 5 clk per nibble -> h0,h1 high, h2 high/low, h3,h4 low.
  // 10M: 50 clk per nibble -> h0..24 high, h25..49 low.
  always_comb begin
    hi_half   = 1'b0;
    h         = cnt;
    nx_txd_d1 = lat_byte[3:0];
    nx_txd_d2 = lat_byte[7:4];
    nx_txc_d1 = 1'b1;
    nx_txc_d2 = 1'b0;
    case (lat_speed)
      SPD_100: begin
        hi_half   = (cnt >= 7'd5);
        h         = hi_half ? (cnt - 7'd5) : cnt;
        nx_txd_d1 = hi_half ? lat_byte[7:4] : lat_byte[3:0];
        nx_txd_d2 = nx_txd_d1;
        nx_txc_d1 = (h < 7'd3);
        nx_txc_d2 = (h < 7'd2);
      end
      SPD_10: begin
        hi_half   = (cnt >= 7'd50);
        h         = hi_half ? (cnt - 7'd50) : cnt;
        nx_txd_d1 = hi_half ? lat_byte[7:4] : lat_byte[3:0];
        nx_txd_d2 = nx_txd_d1;
        nx_txc_d1 = (h < 7'd25);
        nx_txc_d2 = nx_txc_d1;
      end
      default: begin
        nx_txd_d1 = lat_byte[3:0];
        nx_txd_d2 = lat_byte[7:4];
        nx_txc_d1 = 1'b1;
        nx_txc_d2 = 1'b0;
      end
    endcase
  end

  // Byte capture, slot counter and the single output register stage. Outputs are
  // computed from the pre-edge counter, so phase k of a byte captured at edge N
  // appears after edge N+1+k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 7'd0;
      lat_speed <= SPD_1000;
      lat_byte  <= 8'd0;
      lat_en    <= 1'b0;
      lat_er    <= 1'b0;
      txd_d1    <= 4'd0;
      txd_d2    <= 4'd0;
      txctl_d1  <= 1'b0;
      txctl_d2  <= 1'b0;
      txc_d1    <= 1'b0;
      txc_d2    <= 1'b0;
    end else begin
      if (capture) begin
        cnt       <= 7'd0;
        lat_speed <= decode_speed(speed);
        lat_byte  <= gmii.gmii_txd;
        lat_en    <= gmii.gmii_tx_en;
        lat_er    <= gmii.gmii_tx_er;
      end else begin
        cnt <= cnt + 7'd1;
      end
      txd_d1   <= nx_txd_d1;
      txd_d2   <= nx_txd_d2;
      txctl_d1 <= lat_en;
      txctl_d2 <= lat_en ^ lat_er;
      txc_d1   <= nx_txc_d1;
      txc_d2   <= nx_txc_d2;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_gen.sv
// tb_rgmii_tx_gen
// Self-checking bench for rgmii_tx_gen. A reference model turns every captured byte
// into its list of expected per-cycle output tuples and queues them; the DUT must
// play the queue back one entry per clock. gmii_clk_en is expected whenever only
// one entry remains. TXC high/low run lengths are also checked against nominal.
module tb_rgmii_tx_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] speed = 2'b10;
  logic [3:0] txd_d1;
  logic [3:0] txd_d2;
  logic       txctl_d1;
  logic       txctl_d2;
  logic       txc_d1;
  logic       txc_d2;

  rgmii_tx_gen_if gmii_bus ();

  rgmii_tx_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gmii     (gmii_bus),
    .speed    (speed),
    .txd_d1   (txd_d1),
    .txd_d2   (txd_d2),
    .txctl_d1 (txctl_d1),
    .txctl_d2 (txctl_d2),
    .txc_d1   (txc_d1),
    .txc_d2   (txc_d2)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [11:0] outs;  // {txd_d1, txd_d2, txctl_d1, txctl_d2, txc_d1, txc_d2}
    int          nom;   // nominal TXC phase length in half-cycles
  } phase_t;

  phase_t exp_q[$];
  phase_t cur;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic run_valid = 1'b0;
  logic run_level = 1'b0;
  int   run_len   = 0;
  int   run_nom   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected output of one byte, straight from the speed rules: byte period P,
  // low nibble in the first half, TXC high for the first half of each nibble time.
  function automatic void push_byte(input logic [1:0] spd, input logic [7:0] b,
                                    input logic en, input logic er);
    int     p;
    int     half;
    int     hh;
    phase_t e;
    logic [3:0] nib;
    if (spd == 2'b01) p = 10;
    else if (spd == 2'b00) p = 100;
    else p = 1;
    for (int k = 0; k < p; k++) begin
      if (p == 1) begin
        e.outs = {b[3:0], b[7:4], en, en ^ er, 1'b1, 1'b0};
        e.nom  = 1;
      end else begin
        half  = p / 2;
        nib   = (k < half) ? b[3:0] : b[7:4];
        hh    = k % half;
        e.outs = {nib, nib, en, en ^ er, ((2 * hh) < half), ((2 * hh + 1) < half)};
        e.nom  = half;
      end
      exp_q.push_back(e);
    end
  endfunction

  function automatic void reset_model();
    exp_q.delete();
    push_byte(2'b10, 8'h00, 1'b0, 1'b0);
    run_valid = 1'b0;
  endfunction

  task automatic feed_half(input logic b, input int nom);
    if (run_valid && b == run_level) begin
      run_len++;
    end else begin
      if (run_valid) checkOutput("txc_run_len_ok", 32'(run_len >= run_nom), 32'd1);
      run_valid = 1'b1;
      run_level = b;
      run_len   = 1;
      run_nom   = nom;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_outs"}, {20'd0, txd_d1, txd_d2, txctl_d1, txctl_d2, txc_d1, txc_d2}, 32'd0);
    checkOutput({tag, "_clk_en"}, 32'(gmii_bus.gmii_clk_en), 32'd1);
  endtask

  // One clock: the model captures on the edge where exactly one phase was pending,
  // then the DUT is compared at the following falling edge.
  task automatic tick();
    logic cap;
    @(posedge clk);
    cap = (exp_q.size() == 1);
    if (exp_q.size() == 0) begin
      checkOutput("model_queue_empty", 32'd1, 32'd0);
      reset_model();
    end
    cur = exp_q.pop_front();
    if (cap) push_byte(speed, gmii_bus.gmii_txd, gmii_bus.gmii_tx_en, gmii_bus.gmii_tx_er);
    @(negedge clk);
    checkOutput("txd_d1", 32'(txd_d1), 32'(cur.outs[11:8]));
    checkOutput("txd_d2", 32'(txd_d2), 32'(cur.outs[7:4]));
    checkOutput("txctl", {30'd0, txctl_d1, txctl_d2}, {30'd0, cur.outs[3:2]});
    checkOutput("txc", {30'd0, txc_d1, txc_d2}, {30'd0, cur.outs[1:0]});
    checkOutput("gmii_clk_en", 32'(gmii_bus.gmii_clk_en), 32'(exp_q.size() == 1));
    feed_half(txc_d1, cur.nom);
    feed_half(txc_d2, cur.nom);
  endtask

  // Hold the intended byte only on the capture cycle; in between, the MAC-side
  // inputs and speed are scrambled, which the DUT must ignore.
  task automatic applyStimulus(input logic [1:0] spd, input logic [7:0] b,
                               input logic en, input logic er);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 250 && !done; i++) begin
      if (exp_q.size() == 1) begin
        speed               = spd;
        gmii_bus.gmii_txd   = b;
        gmii_bus.gmii_tx_en = en;
        gmii_bus.gmii_tx_er = er;
        done = 1'b1;
      end else begin
        speed               = 2'($urandom);
        gmii_bus.gmii_txd   = 8'($urandom);
        gmii_bus.gmii_tx_en = 1'($urandom);
        gmii_bus.gmii_tx_er = 1'($urandom);
      end
      tick();
    end
    if (!done) checkOutput("capture_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [1:0] rand_speed();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 2'b00;
    if (r < 4) return 2'b01;
    if (r < 6) return 2'b10;
    return 2'b11;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    gmii_bus.gmii_txd   = 8'h00;
    gmii_bus.gmii_tx_en = 1'b0;
    gmii_bus.gmii_tx_er = 1'b0;
    reset_model();

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1000M preamble/SFD/data bytes, then random 1000M traffic
    applyStimulus(2'b10, 8'h55, 1'b1, 1'b0);
    applyStimulus(2'b10, 8'hD5, 1'b1, 1'b0);
    applyStimulus(2'b10, 8'hA3, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      applyStimulus(2'b10, 8'($urandom), 1'($urandom), 1'($urandom));

    // 100M byte, then a 1000M request arriving mid-byte of the next 100M byte
    applyStimulus(2'b01, 8'h3C, 1'b1, 1'b0);
    applyStimulus(2'b01, 8'h96, 1'b1, 1'b0);
    repeat (3) tick();
    speed = 2'b10;
    applyStimulus(2'b10, 8'h12, 1'b1, 1'b0);
    applyStimulus(2'b01, 8'h34, 1'b1, 1'b0);

    // 100M idle with carrier-extend/error encoding
    applyStimulus(2'b01, 8'hFF, 1'b0, 1'b1);
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b1);
    applyStimulus(2'b01, 8'h5A, 1'b0, 1'b0);

    // 10M byte with tx_er set
    applyStimulus(2'b00, 8'h7E, 1'b1, 1'b1);

    // 10M byte interrupted by reset mid-nibble
    applyStimulus(2'b00, 8'hC3, 1'b1, 1'b0);
    repeat (37) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    reset_model();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    applyStimulus(2'b10, 8'hE7, 1'b1, 1'b0);
    applyStimulus(2'b10, 8'h18, 1'b1, 1'b0);

    // Random mixed-speed traffic
    for (int i = 0; i < 40; i++)
      applyStimulus(rand_speed(), 8'($urandom), 1'($urandom), 1'($urandom));

    // Drain whatever byte is still in flight
    repeat (110) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
